// File: rtl/traffic_countdown_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_countdown_ctrl
//
// Intersection phase controller feeding a binary-to-BCD display decoder.
// Sequences north-south / east-west lights through green and yellow phases
// and produces a per-direction countdown in whole seconds. It also emits two
// codes that the decoder reserves: 16'hAAAA (blocked) and 16'hFFFF (blank).
//
// Parameters
//   TICK_DIV  clk cycles per one-second tick (>= 2)
//   GREEN_S   green duration in seconds (>= 1)
//   YELLOW_S  yellow duration in seconds (>= 1, GREEN_S+YELLOW_S <= 99)
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   block_req  in   1   async request: all-red blocked mode
//   disp_en    in   1   async request: countdown display enable
//   ns_light   out  3   {R,Y,G} one-hot, north-south
//   ew_light   out  3   {R,Y,G} one-hot, east-west
//   ns_count   out  16  NS countdown (binary) or reserved code
//   ew_count   out  16  EW countdown (binary) or reserved code
//
// All outputs are registered and reflect the state, remaining seconds and
// synchronized display enable of the previous cycle.
// ---------------------------------------------------------------------------
module traffic_countdown_ctrl #(
  parameter int TICK_DIV = 1000,
  parameter int GREEN_S  = 30,
  parameter int YELLOW_S = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        block_req,
  input  logic        disp_en,
  output logic [2:0]  ns_light,
  output logic [2:0]  ew_light,
  output logic [15:0] ns_count,
  output logic [15:0] ew_count
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [6:0]    GREEN_R  = 7'(GREEN_S);
  localparam logic [6:0]    YELLOW_R = 7'(YELLOW_S);
  localparam logic [15:0]   YELLOW_W = 16'(YELLOW_S);

  localparam logic [2:0]  LIGHT_R    = 3'b100;
  localparam logic [2:0]  LIGHT_Y    = 3'b010;
  localparam logic [2:0]  LIGHT_G    = 3'b001;
  localparam logic [15:0] CODE_BLOCK = 16'hAAAA;
  localparam logic [15:0] CODE_BLANK = 16'hFFFF;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    EW_G  = 3'd2,
    EW_Y  = 3'd3,
    BLOCK = 3'd4
  } state_t;

  // ------------------------------------------------------------------------
  // Input synchronizers. The display defaults to enabled out of reset so the
  // first countdown value is visible immediately.
  // ------------------------------------------------------------------------
  logic blk_meta, blk_s;
  logic dsp_meta, dsp_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_meta <= 1'b0;
      blk_s    <= 1'b0;
      dsp_meta <= 1'b1;
      dsp_s    <= 1'b1;
    end else begin
      blk_meta <= block_req;
      blk_s    <= blk_meta;
      dsp_meta <= disp_en;
      dsp_s    <= dsp_meta;
    end
  end

  // ------------------------------------------------------------------------
  // One-second prescaler. Held at zero while blocked so that leaving BLOCK
  // always starts a full second before the first decrement.
  // ------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [6:0]    rem_q, rem_d;
  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (state_q == BLOCK || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NS_G;
      rem_q   <= GREEN_R;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: next state. A block request wins over a tick arriving in the same
  // cycle; rem is left untouched on entry since BLOCK reloads it on exit.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (state_q == BLOCK) begin
      if (!blk_s) begin
        state_d = NS_G;
        rem_d   = GREEN_R;
      end
    end else if (blk_s) begin
      state_d = BLOCK;
    end else if (tick) begin
      if (rem_q > 7'd1) begin
        rem_d = rem_q - 7'd1;
      end else begin
        case (state_q)
          NS_G:    begin state_d = NS_Y; rem_d = YELLOW_R; end
          NS_Y:    begin state_d = EW_G; rem_d = GREEN_R;  end
          EW_G:    begin state_d = EW_Y; rem_d = YELLOW_R; end
          EW_Y:    begin state_d = NS_G; rem_d = GREEN_R;  end
          default: begin state_d = NS_G; rem_d = GREEN_R;  end
        endcase
      end
    end
  end

  // ------------------------------------------------------------------------
  // FSM: output decode. While one direction is green, the other direction's
  // red lasts for the rest of green plus the whole yellow phase.
  // ------------------------------------------------------------------------
  logic [2:0]  ns_light_d, ew_light_d;
  logic [15:0] ns_count_d, ew_count_d;
  logic [15:0] rem_w;

  assign rem_w = {9'd0, rem_q};

  always_comb begin
    ns_light_d = LIGHT_R;
    ew_light_d = LIGHT_R;
    ns_count_d = rem_w;
    ew_count_d = rem_w;
    case (state_q)
      NS_G: begin
        ns_light_d = LIGHT_G;
        ew_count_d = rem_w + YELLOW_W;
      end
      NS_Y: ns_light_d = LIGHT_Y;
      EW_G: begin
        ew_light_d = LIGHT_G;
        ns_count_d = rem_w + YELLOW_W;
      end
      EW_Y: ew_light_d = LIGHT_Y;
      default: begin
        ns_count_d = CODE_BLOCK;
        ew_count_d = CODE_BLOCK;
      end
    endcase
    // Blank has priority over the blocked code; the FSM keeps running.
    if (!dsp_s) begin
      ns_count_d = CODE_BLANK;
      ew_count_d = CODE_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ns_light <= LIGHT_G;
      ew_light <= LIGHT_R;
      ns_count <= 16'(GREEN_S);
      ew_count <= 16'(GREEN_S + YELLOW_S);
    end else begin
      ns_light <= ns_light_d;
      ew_light <= ew_light_d;
      ns_count <= ns_count_d;
      ew_count <= ew_count_d;
    end
  end

endmodule
